// File: rtl/plant_meas_engine.sv
// -----------------------------------------------------------------------------
// plant_meas_engine
// Plant-side measurement responder. Accepts one measurement request (phase
// codes + input vector), drives the plant DACs, waits a fixed settle time,
// averages AVG_SAMPLES ADC samples per output channel and returns the result.
//
// Ports
//   clk, rst        system clock, synchronous active-high reset
//   abort           cancel the in-flight measurement (ignored in IDLE except
//                   that it blocks acceptance)
//   req_*           request handshake: phase codes and input vector
//   dac_phase/dac_x registered values to the plant, dac_update 1-cycle strobe
//   adc_valid/data  per-channel ADC samples from the plant
//   rsp_*           response handshake: per-channel averages + saturation flag
// -----------------------------------------------------------------------------
module plant_meas_engine #(
    parameter int unsigned PHASE_WIDTH   = 16,
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned ADC_WIDTH     = 12,
    parameter int unsigned NUM_PHASES    = 4,
    parameter int unsigned NUM_OUTPUTS   = 2,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned AVG_SAMPLES   = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              abort,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic [NUM_PHASES*PHASE_WIDTH-1:0] req_phases,
    input  logic [NUM_OUTPUTS*DATA_WIDTH-1:0] req_x,
    output logic [NUM_PHASES*PHASE_WIDTH-1:0] dac_phase,
    output logic [NUM_OUTPUTS*DATA_WIDTH-1:0] dac_x,
    output logic                              dac_update,
    input  logic                              adc_valid,
    input  logic [NUM_OUTPUTS*ADC_WIDTH-1:0]  adc_data,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [NUM_OUTPUTS*ADC_WIDTH-1:0]  rsp_data,
    output logic                              rsp_saturated
);

    localparam int unsigned PH_BUS_W  = NUM_PHASES * PHASE_WIDTH;
    localparam int unsigned X_BUS_W   = NUM_OUTPUTS * DATA_WIDTH;
    localparam int unsigned ADC_BUS_W = NUM_OUTPUTS * ADC_WIDTH;
    localparam int unsigned AVG_SHIFT = $clog2(AVG_SAMPLES);
    localparam int unsigned ACC_W     = ADC_WIDTH + AVG_SHIFT;
    localparam int unsigned SET_W     = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int unsigned CNT_W     = (AVG_SAMPLES > 1) ? AVG_SHIFT : 1;

    // Parameter sanity: averaging relies on a plain right shift.
    if (AVG_SAMPLES == 0 || (AVG_SAMPLES & (AVG_SAMPLES - 1)) != 0) begin : g_bad_avg
        $error("plant_meas_engine: AVG_SAMPLES must be a power of 2 and >= 1");
    end
    if (SETTLE_CYCLES == 0) begin : g_bad_settle
        $error("plant_meas_engine: SETTLE_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [SET_W-1:0]       settle_cnt_q, settle_cnt_d;
    logic [CNT_W-1:0]       samp_cnt_q, samp_cnt_d;
    logic [ACC_W-1:0]       acc_q [NUM_OUTPUTS];
    logic [ACC_W-1:0]       acc_d [NUM_OUTPUTS];
    logic                   sat_q, sat_d;
    logic [PH_BUS_W-1:0]    dac_phase_q, dac_phase_d;
    logic [X_BUS_W-1:0]     dac_x_q, dac_x_d;
    logic                   dac_update_q, dac_update_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [ADC_BUS_W-1:0]   rsp_data_q, rsp_data_d;
    logic                   rsp_sat_q, rsp_sat_d;

    logic [ADC_WIDTH-1:0]   sample_c  [NUM_OUTPUTS];
    logic [ACC_W-1:0]       acc_sum_c [NUM_OUTPUTS];
    logic                   sample_sat_c;
    logic                   req_fire_c;

    // Only IDLE accepts; abort and reset both block the handshake.
    assign req_ready  = (state_q == ST_IDLE) && !abort && !rst;
    assign req_fire_c = req_valid && req_ready;

    // Per-channel sample extraction, running sums and saturation detect.
    always_comb begin
        sample_sat_c = 1'b0;
        for (int k = 0; k < int'(NUM_OUTPUTS); k++) begin
            sample_c[k]  = adc_data[k*ADC_WIDTH +: ADC_WIDTH];
            acc_sum_c[k] = acc_q[k] + ACC_W'(sample_c[k]);
            if (sample_c[k] == '0 || sample_c[k] == '1) begin
                sample_sat_c = 1'b1;
            end
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        samp_cnt_d   = samp_cnt_q;
        sat_d        = sat_q;
        dac_phase_d  = dac_phase_q;
        dac_x_d      = dac_x_q;
        dac_update_d = 1'b0;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        rsp_sat_d    = rsp_sat_q;
        for (int k = 0; k < int'(NUM_OUTPUTS); k++) begin
            acc_d[k] = acc_q[k];
        end

        unique case (state_q)
            ST_IDLE: begin
                if (req_fire_c) begin
                    dac_phase_d  = req_phases;
                    dac_x_d      = req_x;
                    dac_update_d = 1'b1;
                    settle_cnt_d = SET_W'(SETTLE_CYCLES - 1);
                    samp_cnt_d   = '0;
                    sat_d        = 1'b0;
                    for (int k = 0; k < int'(NUM_OUTPUTS); k++) begin
                        acc_d[k] = '0;
                    end
                    state_d = ST_SETTLE;
                end
            end

            ST_SETTLE: begin
                // ADC traffic during settle is deliberately ignored.
                if (settle_cnt_q == '0) begin
                    state_d = ST_SAMPLE;
                end else begin
                    settle_cnt_d = settle_cnt_q - SET_W'(1);
                end
            end

            ST_SAMPLE: begin
                if (adc_valid) begin
                    for (int k = 0; k < int'(NUM_OUTPUTS); k++) begin
                        acc_d[k] = acc_sum_c[k];
                    end
                    sat_d = sat_q | sample_sat_c;
                    if (samp_cnt_q == CNT_W'(AVG_SAMPLES - 1)) begin
                        // Last sample: result includes this cycle's data.
                        for (int k = 0; k < int'(NUM_OUTPUTS); k++) begin
                            rsp_data_d[k*ADC_WIDTH +: ADC_WIDTH] =
                                ADC_WIDTH'(acc_sum_c[k] >> AVG_SHIFT);
                        end
                        rsp_sat_d   = sat_q | sample_sat_c;
                        rsp_valid_d = 1'b1;
                        state_d     = ST_RESP;
                    end else begin
                        samp_cnt_d = samp_cnt_q + CNT_W'(1);
                    end
                end
            end

            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort overrides everything outside IDLE; the previous result and the
        // DAC values stay, partial sums are dropped.
        if (abort && (state_q != ST_IDLE)) begin
            state_d     = ST_IDLE;
            rsp_valid_d = 1'b0;
            rsp_data_d  = rsp_data_q;
            rsp_sat_d   = rsp_sat_q;
            sat_d       = 1'b0;
            samp_cnt_d  = '0;
            for (int k = 0; k < int'(NUM_OUTPUTS); k++) begin
                acc_d[k] = '0;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            settle_cnt_q <= '0;
            samp_cnt_q   <= '0;
            sat_q        <= 1'b0;
            dac_phase_q  <= '0;
            dac_x_q      <= '0;
            dac_update_q <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_sat_q    <= 1'b0;
            for (int k = 0; k < int'(NUM_OUTPUTS); k++) begin
                acc_q[k] <= '0;
            end
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            samp_cnt_q   <= samp_cnt_d;
            sat_q        <= sat_d;
            dac_phase_q  <= dac_phase_d;
            dac_x_q      <= dac_x_d;
            dac_update_q <= dac_update_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_sat_q    <= rsp_sat_d;
            for (int k = 0; k < int'(NUM_OUTPUTS); k++) begin
                acc_q[k] <= acc_d[k];
            end
        end
    end

    assign dac_phase     = dac_phase_q;
    assign dac_x         = dac_x_q;
    assign dac_update    = dac_update_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = rsp_data_q;
    assign rsp_saturated = rsp_sat_q;

endmodule

// File: tb/tb_plant_meas_engine.sv
// -----------------------------------------------------------------------------
// tb_plant_meas_engine
// Scoreboard bench: each issued measurement pushes its expected averaged
// result; an independent monitor pops and compares on every response
// handshake and also checks response stability and hold behaviour.
// -----------------------------------------------------------------------------
module tb_plant_meas_engine;

    localparam int unsigned PW = 16;
    localparam int unsigned DW = 16;
    localparam int unsigned AW = 12;
    localparam int unsigned NP = 4;
    localparam int unsigned NO = 2;
    localparam int unsigned SC = 16;
    localparam int unsigned AS = 8;
    localparam int unsigned PH_BUS_W  = NP * PW;
    localparam int unsigned X_BUS_W   = NO * DW;
    localparam int unsigned ADC_BUS_W = NO * AW;
    localparam int unsigned ADC_MAX   = (1 << AW) - 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 abort;
    logic                 req_valid;
    logic                 req_ready;
    logic [PH_BUS_W-1:0]  req_phases;
    logic [X_BUS_W-1:0]   req_x;
    logic [PH_BUS_W-1:0]  dac_phase;
    logic [X_BUS_W-1:0]   dac_x;
    logic                 dac_update;
    logic                 adc_valid;
    logic [ADC_BUS_W-1:0] adc_data;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [ADC_BUS_W-1:0] rsp_data;
    logic                 rsp_saturated;

    plant_meas_engine #(
        .PHASE_WIDTH(PW), .DATA_WIDTH(DW), .ADC_WIDTH(AW), .NUM_PHASES(NP),
        .NUM_OUTPUTS(NO), .SETTLE_CYCLES(SC), .AVG_SAMPLES(AS)
    ) dut (
        .clk(clk), .rst(rst), .abort(abort),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_phases(req_phases), .req_x(req_x),
        .dac_phase(dac_phase), .dac_x(dac_x), .dac_update(dac_update),
        .adc_valid(adc_valid), .adc_data(adc_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_saturated(rsp_saturated)
    );

    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned bad   = 0;
    int          rdy_mode = 0;      // 0: always ready, 1: random, 2: stalled
    int unsigned smp [NO][AS];      // samples for the next measurement
    logic [ADC_BUS_W:0] exp_q [$];  // {sat, data}

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: truncated mean per channel, saturation if any sample is at a rail.
    function automatic logic [ADC_BUS_W:0] ref_result();
        logic [ADC_BUS_W:0] r;
        int unsigned sum;
        r = '0;
        for (int c = 0; c < int'(NO); c++) begin
            sum = 0;
            for (int i = 0; i < int'(AS); i++) begin
                sum += smp[c][i];
                if (smp[c][i] == 0 || smp[c][i] == ADC_MAX) r[ADC_BUS_W] = 1'b1;
            end
            r[c*AW +: AW] = AW'(sum / AS);
        end
        return r;
    endfunction

    function automatic int unsigned rand_sample();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r == 0) return 0;
        if (r == 1) return ADC_MAX;
        return $urandom_range(1, ADC_MAX - 1);
    endfunction

    // Response consumer.
    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       rsp_ready = 1'b1;
                1:       rsp_ready = 1'($urandom_range(0, 1));
                default: rsp_ready = 1'b0;
            endcase
        end
    end

    // Monitor: scoreboard pop on handshake, stability while stalled, hold when idle.
    logic [ADC_BUS_W:0] last_v;
    logic [ADC_BUS_W:0] prev_v;
    logic [ADC_BUS_W:0] got_v;
    logic [ADC_BUS_W:0] want_v;
    bit                 pend;
    initial begin
        last_v = '0;
        prev_v = '0;
        pend   = 1'b0;
        forever begin
            @(negedge clk);
            got_v = {rsp_saturated, rsp_data};
            if (rst) begin
                last_v = '0;
                pend   = 1'b0;
            end else begin
                if (pend) begin
                    chk("stall_valid", rsp_valid, 1'b1);
                    chk("stall_data", got_v, prev_v);
                end
                if (rsp_valid) begin
                    last_v = got_v;
                    prev_v = got_v;
                    if (rsp_ready && !abort) begin
                        pend = 1'b0;
                        if (exp_q.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL unexpected_rsp: got %h expected no response", got_v);
                        end else begin
                            want_v = exp_q.pop_front();
                            chk("rsp_data", rsp_data, want_v[ADC_BUS_W-1:0]);
                            chk("rsp_saturated", rsp_saturated, want_v[ADC_BUS_W]);
                        end
                    end else begin
                        pend = !abort;
                    end
                end else begin
                    pend = 1'b0;
                    chk("idle_hold", got_v, last_v);
                end
            end
        end
    end

    // One measurement; gap_mode 0 continuous, 1 alternate, 2 random.
    // abort_at < 0: none; 0..AS-1: abort before that sample; AS: abort in response.
    task automatic do_meas(input logic [PH_BUS_W-1:0] ph, input logic [X_BUS_W-1:0] xv,
                           input int gap_mode, input int abort_at);
        int  n;
        int  j;
        int  cyc;
        bit  gap;
        bit  aborted;
        req_phases = ph;
        req_x      = xv;
        req_valid  = 1'b1;
        n = 0;
        while (!req_ready && n < 500) begin
            step();
            n++;
        end
        if (!req_ready) begin
            chk("req_ready_timeout", req_ready, 1'b1);
            req_valid = 1'b0;
            return;
        end
        if (abort_at < 0) exp_q.push_back(ref_result());
        step();                                   // accept edge
        req_valid  = 1'b0;
        req_phases = {$urandom, $urandom};
        req_x      = $urandom;
        // Settle: junk with adc_valid high must be ignored.
        for (int i = 0; i < int'(SC); i++) begin
            adc_valid = 1'b1;
            adc_data  = ($urandom_range(0, 3) == 0) ? '0 : ADC_BUS_W'($urandom);
            @(negedge clk);
            if (i == 0) begin
                chk("dac_update_pulse", dac_update, 1'b1);
                chk("dac_phase", dac_phase, ph);
                chk("dac_x", dac_x, xv);
                chk("settle_no_rsp", rsp_valid, 1'b0);
            end
            if (i == 1) chk("dac_update_single", dac_update, 1'b0);
            step();
        end
        j = 0;
        cyc = 0;
        aborted = 1'b0;
        while (j < int'(AS)) begin
            if (abort_at == j) begin
                adc_valid = 1'b0;
                abort = 1'b1;
                step();
                abort = 1'b0;
                @(negedge clk);
                chk("abort_no_rsp", rsp_valid, 1'b0);
                chk("abort_idle", req_ready, 1'b1);
                aborted = 1'b1;
                break;
            end
            case (gap_mode)
                0:       gap = 1'b0;
                1:       gap = (cyc % 2) == 1;
                default: gap = ($urandom_range(0, 2) == 0);
            endcase
            if (gap) begin
                adc_valid = 1'b0;
                adc_data  = '0;
            end else begin
                adc_valid = 1'b1;
                for (int c = 0; c < int'(NO); c++) adc_data[c*AW +: AW] = AW'(smp[c][j]);
                j++;
            end
            @(negedge clk);
            chk("early_rsp", rsp_valid, 1'b0);
            step();
            cyc++;
        end
        if (!aborted) begin
            adc_valid = 1'b0;
            if (abort_at == int'(AS)) abort = 1'b1;
            @(negedge clk);
            chk("rsp_latency", rsp_valid, 1'b1);
            if (abort_at == int'(AS)) begin
                step();
                abort = 1'b0;
                @(negedge clk);
                chk("abort_resp_drop", rsp_valid, 1'b0);
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        abort      = 1'b0;
        req_valid  = 1'b1;
        req_phases = 64'hDEAD_BEEF_1234_5678;
        req_x      = 32'hCAFE_F00D;
        adc_valid  = 1'b0;
        adc_data   = '0;

        // T1 reset
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            chk("rst_req_ready", req_ready, 1'b0);
            chk("rst_dac_update", dac_update, 1'b0);
            chk("rst_rsp_valid", rsp_valid, 1'b0);
            chk("rst_dac_phase", dac_phase, '0);
            chk("rst_dac_x", dac_x, '0);
            chk("rst_rsp", {rsp_saturated, rsp_data}, '0);
        end
        step();
        rst = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", req_ready, 1'b1);

        // T2 basic, continuous samples
        for (int i = 0; i < int'(AS); i++) begin smp[0][i] = 'h800; smp[1][i] = 'h123; end
        do_meas({4{16'h1000}}, {16'h0000, 16'h7FFF}, 0, -1);

        // T3 gapped samples, truncating mean
        for (int i = 0; i < int'(AS); i++) begin smp[0][i] = i + 1; smp[1][i] = 'h555; end
        do_meas({4{16'h2000}}, {16'h7FFF, 16'h0000}, 1, -1);

        // T4 saturation then clean
        for (int i = 0; i < int'(AS); i++) begin smp[0][i] = 'h800; smp[1][i] = 'h400; end
        smp[0][AS-1] = ADC_MAX;
        do_meas({4{16'h0400}}, 32'h1234_5678, 0, -1);
        smp[0][AS-1] = 'h800;
        do_meas({4{16'h0800}}, 32'h1111_2222, 2, -1);

        // T5 backpressure: stalled result, requests refused meanwhile
        rdy_mode = 2;
        for (int i = 0; i < int'(AS); i++) begin smp[0][i] = rand_sample(); smp[1][i] = rand_sample(); end
        do_meas({$urandom, $urandom}, $urandom, 0, -1);
        req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            @(negedge clk);
            chk("bp_req_ready", req_ready, 1'b0);
        end
        req_valid = 1'b0;
        rdy_mode  = 0;

        // T6 abort after 4th sample, then exact follow-up
        for (int i = 0; i < int'(AS); i++) begin smp[0][i] = 'hABC; smp[1][i] = 'h001; end
        do_meas({4{16'h3000}}, 32'h0, 0, 4);
        for (int i = 0; i < int'(AS); i++) begin smp[0][i] = 'h100; smp[1][i] = 'h200; end
        do_meas({4{16'h3001}}, 32'h1, 0, -1);

        // Abort in response with consumer ready: no handshake may happen
        for (int i = 0; i < int'(AS); i++) begin smp[0][i] = 'h777; smp[1][i] = 'h888; end
        do_meas({4{16'h3002}}, 32'h2, 0, int'(AS));

        // Mid-operation reset
        req_phases = {4{16'h5555}};
        req_x      = 32'h6666_7777;
        req_valid  = 1'b1;
        step();
        req_valid = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();
        @(negedge clk);
        chk("midrst_dac_phase", dac_phase, '0);
        chk("midrst_dac_x", dac_x, '0);
        chk("midrst_rsp_valid", rsp_valid, 1'b0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_ready", req_ready, 1'b1);

        // Randomized measurements
        for (int t = 0; t < 24; t++) begin
            int ab;
            rdy_mode = int'($urandom_range(0, 1));
            for (int c = 0; c < int'(NO); c++)
                for (int i = 0; i < int'(AS); i++) smp[c][i] = rand_sample();
            ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, AS)) : -1;
            do_meas({$urandom, $urandom}, $urandom, 2, ab);
        end

        // Drain
        rdy_mode = 0;
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) step();
        repeat (3) step();
        chk("drain_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, bad=%0d", bad);
        $fatal(1, "watchdog expired");
    end

endmodule
